if_fetch_ctrl: RTL and testbench

Fetch-stage controller. It sequences the IF datapath (PC register, next-PC mux, instruction cache, IF/ID register). Each cycle it selects the next-PC source, drives PCWrite / IFIDWrite / IF_Flush, and runs an instruction-cache line refill on a miss. A redirect that arrives mid-refill is captured and applied once the refill finishes.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
//   fetch_state_e : FSM state encoding (RUN, FILL, RESUME)
//   PCSEL_*       : next-PC mux select codes driven on PC_SEL
package if_fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FILL   = 2'b01,
    RESUME = 2'b10
  } fetch_state_e;

  localparam logic [1:0] PCSEL_PC4  = 2'b00;
  localparam logic [1:0] PCSEL_JUMP = 2'b01;
  localparam logic [1:0] PCSEL_BTB  = 2'b10;
  localparam logic [1:0] PCSEL_PEND = 2'b11;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: selects the next-PC source, drives PCWrite /
// IFIDWrite / IF_Flush and sequences an I-cache line refill on a miss.
// A redirect seen during a refill is held in PEND_Addr and applied in the
// single RESUME cycle that follows the refill.
//
// Ports
//   CLK, RESET_N          clock (rising edge), async active-low reset
//   PC                    current PC register value
//   JUMP / JUMP_Addr      jump request and target from ID
//   Branch / BTB_Addr     BTB-taken request and target
//   Hazard_Stall          load-use stall
//   IC_HIT                combinational I-cache hit for PC
//   MEM_ACK               one refill word returned this cycle
//   PC_SEL                next-PC mux select (PC+4 / JUMP / BTB / PEND)
//   PEND_Addr             captured redirect target
//   PCWrite, IFIDWrite, IF_Flush  pipeline controls
//   MEM_REQ, MEM_ADDR     refill request and word address (registered state only)
//   IC_FILL_WE, IC_FILL_IDX  cache fill write enable and word index
//   STATE_DBG             current FSM state, for observation
//
// Handshake: a refill word transfers on any cycle where MEM_REQ and MEM_ACK
// are both high. MEM_REQ/MEM_ADDR are held stable until that cycle; MEM_ACK
// with MEM_REQ low has no effect.
module if_fetch_ctrl
  import if_fetch_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] PC,
  input  logic              JUMP,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] JUMP_Addr,
  input  logic [ADDR_W-1:0] BTB_Addr,
  input  logic              Hazard_Stall,
  input  logic              IC_HIT,
  input  logic              MEM_ACK,
  output logic [1:0]        PC_SEL,
  output logic [ADDR_W-1:0] PEND_Addr,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IF_Flush,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              IC_FILL_WE,
  output logic [IDX_W-1:0]  IC_FILL_IDX,
  output logic [1:0]        STATE_DBG
);

  // Clears the word-in-line and byte-in-word bits of an address.
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << (IDX_W + 2)) - ADDR_W'(1));
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(LINE_WORDS - 1);

  fetch_state_e      state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] miss_base_q, miss_base_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic [1:0] pc_sel_c;
  logic       pcwrite_c, ifidwrite_c, flush_c, fill_we_c;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      miss_base_q <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_base_q <= miss_base_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_base_d = miss_base_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pc_sel_c    = PCSEL_PC4;
    pcwrite_c   = 1'b0;
    ifidwrite_c = 1'b0;
    flush_c     = 1'b0;
    fill_we_c   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (Hazard_Stall) begin
          // Freeze; the stalled ID instruction will re-present any redirect.
        end else if (Branch || JUMP) begin
          // Redirect beats a miss: the missing fetch is on the wrong path.
          pc_sel_c    = Branch ? PCSEL_BTB : PCSEL_JUMP;
          pcwrite_c   = 1'b1;
          ifidwrite_c = 1'b1;
          flush_c     = 1'b1;
        end else if (!IC_HIT) begin
          ifidwrite_c = 1'b1;
          flush_c     = 1'b1;
          miss_base_d = PC & LINE_MASK;
          cnt_d       = '0;
          state_d     = FILL;
        end else begin
          pcwrite_c   = 1'b1;
          ifidwrite_c = 1'b1;
        end
      end

      FILL: begin
        ifidwrite_c = !Hazard_Stall;
        flush_c     = !Hazard_Stall;
        if (MEM_ACK) begin
          fill_we_c = 1'b1;
          cnt_d     = cnt_q + IDX_W'(1);
          if (cnt_q == CNT_LAST) state_d = RESUME;
        end
        // First redirect during the refill is kept; later ones are dropped.
        if ((Branch || JUMP) && !pend_q) begin
          pend_d      = 1'b1;
          pend_addr_d = Branch ? BTB_Addr : JUMP_Addr;
        end
      end

      RESUME: begin
        ifidwrite_c = 1'b1;
        flush_c     = 1'b1;
        if (pend_q) begin
          pc_sel_c  = PCSEL_PEND;
          pcwrite_c = 1'b1;
          pend_d    = 1'b0;
        end
        // Without a pending redirect this is a bubble while the array settles.
        state_d = RUN;
      end

      default: state_d = RUN;
    endcase
  end

  // Combinational controls are forced low while reset is asserted so that
  // every output reads 0 during reset regardless of the inputs.
  assign PC_SEL      = RESET_N ? pc_sel_c    : PCSEL_PC4;
  assign PCWrite     = RESET_N && pcwrite_c;
  assign IFIDWrite   = RESET_N && ifidwrite_c;
  assign IF_Flush    = RESET_N && flush_c;
  assign IC_FILL_WE  = RESET_N && fill_we_c;
  assign IC_FILL_IDX = cnt_q;

  // miss_base_q is line aligned, so OR-ing the word offset is the addition.
  assign MEM_REQ   = (state_q == FILL);
  assign MEM_ADDR  = miss_base_q | {{(ADDR_W - IDX_W - 2){1'b0}}, cnt_q, 2'b00};
  assign PEND_Addr = pend_addr_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  localparam int LW = 4;
  localparam int AW = 32;

  logic          CLK, RESET_N;
  logic [AW-1:0] PC, JUMP_Addr, BTB_Addr;
  logic          JUMP, Branch, Hazard_Stall, IC_HIT, MEM_ACK;
  logic [1:0]    PC_SEL, STATE_DBG;
  logic [AW-1:0] PEND_Addr, MEM_ADDR;
  logic          PCWrite, IFIDWrite, IF_Flush, MEM_REQ, IC_FILL_WE;
  logic [1:0]    IC_FILL_IDX;

  int n_tests = 0;
  int n_fail  = 0;

  // {PC_SEL, PCWrite, IFIDWrite, IF_Flush}
  logic [4:0] ctl;
  assign ctl = {PC_SEL, PCWrite, IFIDWrite, IF_Flush};

  if_fetch_ctrl #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC(PC), .JUMP(JUMP), .Branch(Branch),
    .JUMP_Addr(JUMP_Addr), .BTB_Addr(BTB_Addr), .Hazard_Stall(Hazard_Stall),
    .IC_HIT(IC_HIT), .MEM_ACK(MEM_ACK), .PC_SEL(PC_SEL), .PEND_Addr(PEND_Addr),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IF_Flush(IF_Flush),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .IC_FILL_WE(IC_FILL_WE),
    .IC_FILL_IDX(IC_FILL_IDX), .STATE_DBG(STATE_DBG)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    JUMP = 0; Branch = 0; Hazard_Stall = 0; IC_HIT = 1; MEM_ACK = 0;
    JUMP_Addr = '0; BTB_Addr = '0; PC = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET_N = 0;
    idle_inputs();
    JUMP = 1; JUMP_Addr = 32'h55; MEM_ACK = 1;
    #3;
    n_tests++;
    if (ctl !== 5'b00_000) begin
      $display("FAIL reset_ctl got %b exp 00000", ctl); n_fail++;
    end
    n_tests++;
    if ({MEM_REQ, IC_FILL_WE} !== 2'b00 || PEND_Addr !== '0 || STATE_DBG !== 2'd0) begin
      $display("FAIL reset_misc req=%b we=%b pend=%h st=%0d exp 0 0 0 0",
               MEM_REQ, IC_FILL_WE, PEND_Addr, STATE_DBG); n_fail++;
    end
    step(); step();
    RESET_N = 1;
    idle_inputs();
    step();
  endtask

  task automatic test_hit_stream();
    for (int i = 0; i < 3; i++) begin
      PC = 32'h20 + 32'(4 * i); IC_HIT = 1; MEM_ACK = (i == 1);
      #1;
      n_tests++;
      if (ctl !== 5'b00_110 || IC_FILL_WE !== 1'b0 || MEM_REQ !== 1'b0) begin
        $display("FAIL hit_stream[%0d] ctl=%b we=%b req=%b exp 00110 0 0",
                 i, ctl, IC_FILL_WE, MEM_REQ); n_fail++;
      end
      step();
    end
  endtask

  task automatic test_redirect();
    Branch = 1; JUMP = 1; BTB_Addr = 32'h10; JUMP_Addr = 32'h300; IC_HIT = 0;
    #1;
    n_tests++;
    if (ctl !== 5'b10_111) begin
      $display("FAIL branch_over_jump ctl=%b exp 10111", ctl); n_fail++;
    end
    step();
    n_tests++;
    if (STATE_DBG !== 2'd0) begin
      $display("FAIL redirect_ignores_miss state=%0d exp 0", STATE_DBG); n_fail++;
    end
    Branch = 0; JUMP = 1; IC_HIT = 1;
    #1;
    n_tests++;
    if (ctl !== 5'b01_111) begin
      $display("FAIL jump_only ctl=%b exp 01111", ctl); n_fail++;
    end
    step();
    idle_inputs();
  endtask

  // Miss at PC=0x48; gap = idle cycles before each ACK.
  task automatic test_miss(input int gap, input string tag);
    PC = 32'h48; IC_HIT = 0;
    #1;
    n_tests++;
    if (ctl !== 5'b00_011) begin
      $display("FAIL %s_detect ctl=%b exp 00011", tag, ctl); n_fail++;
    end
    step();
    IC_HIT = 0;
    for (int k = 0; k < LW; k++) begin
      for (int g = 0; g < gap; g++) begin
        MEM_ACK = 0;
        #1;
        n_tests++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h40 + 32'(4 * k) || IC_FILL_WE !== 1'b0) begin
          $display("FAIL %s_hold[%0d] req=%b addr=%h we=%b exp 1 %h 0",
                   tag, k, MEM_REQ, MEM_ADDR, IC_FILL_WE, 32'h40 + 32'(4 * k)); n_fail++;
        end
        step();
      end
      MEM_ACK = 1;
      #1;
      n_tests++;
      if (MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h40 + 32'(4 * k) ||
          IC_FILL_WE !== 1'b1 || IC_FILL_IDX !== 2'(k) || ctl !== 5'b00_011) begin
        $display("FAIL %s_ack[%0d] req=%b addr=%h we=%b idx=%0d ctl=%b exp 1 %h 1 %0d 00011",
                 tag, k, MEM_REQ, MEM_ADDR, IC_FILL_WE, IC_FILL_IDX, ctl,
                 32'h40 + 32'(4 * k), k); n_fail++;
      end
      step();
    end
    MEM_ACK = 1;
    #1;
    n_tests++;
    if (STATE_DBG !== 2'd2 || ctl !== 5'b00_011 || MEM_REQ !== 1'b0 || IC_FILL_WE !== 1'b0) begin
      $display("FAIL %s_resume st=%0d ctl=%b req=%b we=%b exp 2 00011 0 0",
               tag, STATE_DBG, ctl, MEM_REQ, IC_FILL_WE); n_fail++;
    end
    step();
    MEM_ACK = 0; IC_HIT = 1;
    #1;
    n_tests++;
    if (STATE_DBG !== 2'd0 || ctl !== 5'b00_110) begin
      $display("FAIL %s_refetch st=%0d ctl=%b exp 0 00110", tag, STATE_DBG, ctl); n_fail++;
    end
    step();
    idle_inputs();
  endtask

  task automatic test_pending();
    PC = 32'h48; IC_HIT = 0;
    step();
    JUMP = 1; JUMP_Addr = 32'h100; MEM_ACK = 1;
    step();
    JUMP = 0; Branch = 1; BTB_Addr = 32'h200;
    #1;
    n_tests++;
    if (PEND_Addr !== 32'h100) begin
      $display("FAIL pend_capture got %h exp 00000100", PEND_Addr); n_fail++;
    end
    step();
    Branch = 0;
    step(); step();
    MEM_ACK = 0;
    #1;
    n_tests++;
    if (STATE_DBG !== 2'd2 || ctl !== 5'b11_111 || PEND_Addr !== 32'h100) begin
      $display("FAIL pend_resume st=%0d ctl=%b pend=%h exp 2 11111 00000100",
               STATE_DBG, ctl, PEND_Addr); n_fail++;
    end
    step();
    IC_HIT = 1;
    #1;
    n_tests++;
    if (ctl !== 5'b00_110) begin
      $display("FAIL pend_after ctl=%b exp 00110", ctl); n_fail++;
    end
    step();
    // A second refill without redirects must not replay the old pending one.
    PC = 32'h80; IC_HIT = 0;
    step();
    MEM_ACK = 1;
    step(); step(); step(); step();
    MEM_ACK = 0;
    #1;
    n_tests++;
    if (STATE_DBG !== 2'd2 || ctl !== 5'b00_011) begin
      $display("FAIL pend_cleared st=%0d ctl=%b exp 2 00011", STATE_DBG, ctl); n_fail++;
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_stall();
    Hazard_Stall = 1; Branch = 1; BTB_Addr = 32'h44; IC_HIT = 0; PC = 32'h60;
    #1;
    n_tests++;
    if (ctl[2:0] !== 3'b000) begin
      $display("FAIL stall_ctl pcw/ifid/flush=%b exp 000", ctl[2:0]); n_fail++;
    end
    step();
    #1;
    n_tests++;
    if (STATE_DBG !== 2'd0 || MEM_REQ !== 1'b0) begin
      $display("FAIL stall_state st=%0d req=%b exp 0 0", STATE_DBG, MEM_REQ); n_fail++;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_fill();
    PC = 32'h48; IC_HIT = 0;
    step();
    MEM_ACK = 1;
    step(); step();
    RESET_N = 0;
    #1;
    n_tests++;
    if (MEM_REQ !== 1'b0 || STATE_DBG !== 2'd0 || IC_FILL_IDX !== 2'd0) begin
      $display("FAIL reset_mid_fill req=%b st=%0d idx=%0d exp 0 0 0",
               MEM_REQ, STATE_DBG, IC_FILL_IDX); n_fail++;
    end
    step();
    RESET_N = 1;
    MEM_ACK = 0;
    PC = 32'h84; IC_HIT = 0;
    step();
    MEM_ACK = 1;
    #1;
    n_tests++;
    if (MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h80 || IC_FILL_IDX !== 2'd0 || IC_FILL_WE !== 1'b1) begin
      $display("FAIL restart_fill req=%b addr=%h idx=%0d we=%b exp 1 00000080 0 1",
               MEM_REQ, MEM_ADDR, IC_FILL_IDX, IC_FILL_WE); n_fail++;
    end
    step(); step(); step();
    MEM_ACK = 0;
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_hit_stream();
    test_redirect();
    test_miss(0, "miss_fast");
    test_miss(2, "miss_slow");
    test_pending();
    test_stall();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
